uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte queue and launch sequencer directly upstream of the Uart transmitter.
- Accepts bytes from system logic (keypad, sensor, or CPU glue) at any rate and buffers them in a FIFO.
- Feeds the bytes to the Uart one at a time over the TxInit/TxData/TxDone handshake, so producers never poll TxDone.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, 2..256).
- ADDR_W, 4, log2(DEPTH).

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- WrData  in  8  byte to enqueue.
- WrEn  in  1  enqueue strobe, one byte per cycle when high.
- Full  out  1  FIFO holds DEPTH bytes.
- Empty  out  1  FIFO holds 0 bytes.
- Level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- Overflow  out  1  sticky: a write was dropped.
- ClrOvf  in  1  clears Overflow.
- TxInit  out  1  launch request to Uart; level, held until TxDone.
- TxData  out  8  byte to Uart; stable whenever TxInit=1.
- TxDone  in  1  from Uart: byte finished; pulse or level.
- Busy  out  1  FSM not IDLE, or FIFO not empty.

Behaviour:
- Reset (async assert, sync release): Full=0, Empty=1, Level=0, Overflow=0, TxInit=0, TxData=8'h00, Busy=0, FSM=IDLE, pointers=0.
- Reset mid-frame: TxInit drops immediately and FIFO contents are discarded. Uart is reset by the same Reset.
- Write: WrEn=1 and Full=0 stores WrData at the write pointer. Empty/Level/Full update on the next edge.
- Write while Full: byte dropped, Overflow<=1. Overflow holds until ClrOvf=1. If ClrOvf and a dropped write occur in the same cycle, set wins.
- Full is the registered flag. A write is dropped while Full=1 even if a pop occurs in the same cycle.
- Simultaneous write and pop with 0<Level<DEPTH: Level unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Level is computed from an ADDR_W+1-bit count.
- FSM states:
  - IDLE: if !Empty -> LOAD.
  - LOAD: TxData<=head, pop -> SEND.
  - SEND: TxInit=1. When TxDone=1, TxInit<=0 -> REL.
  - REL: TxInit=0. Wait until TxDone=0 (handles level-style TxDone), then -> IDLE.
- Latency: a write into an empty idle queue gives TxInit=1 on the 3rd rising edge after the WrEn edge (write, IDLE detect, LOAD).
- Back-to-back bytes: minimum 3 cycles between TxDone sampled and the next TxInit rise.
- TxData changes only in LOAD, so it is never altered while TxInit=1.
- TxDone sampled in IDLE/LOAD is ignored.
- Busy=1 when state!=IDLE or Empty=0.

Optional Feature:
- Macro: UART_TX_CRLF_EN.
- Defined: when head byte is 8'h0A and the internal flag cr_sent=0:
  - LOAD drives TxData=8'h0D without popping and sets cr_sent.
  - After that frame completes, LOAD sends 8'h0A, pops, and clears cr_sent.
  - A lone LF therefore occupies one FIFO slot and produces two frames.
  - Reset clears cr_sent.
- Undefined: bytes are transmitted verbatim; the cr_sent logic is absent.

Decomposition:
- Shared package/header uart_pkg holds:
  - FSM state encodings IDLE/LOAD/SEND/REL.
  - ASCII constants CR=8'h0D, LF=8'h0A.
  - Baud divisor constant 16'd1302 (50 MHz, 38400 baud), used by integrating tops.
- One sub-module, uart_fifo_mem: synchronous DEPTH x 8 FIFO storage with pointers, Full/Empty/Level.
  - Instantiated once; FSM and handshake logic stay in uart_tx_queue.

Test Plan:
- Reset, then write 8'h41 into empty queue -> TxInit=1 on 3rd edge with TxData=8'h41. Uart model asserts TxDone 20 cycles later -> TxInit=0 next edge; Busy=0 after REL.
- Burst-write 8'h30..8'h3F (16 bytes, DEPTH=16) in 16 consecutive cycles -> Full=1, Level=16, Overflow=0. Model transmits 16 frames in order 8'h30..8'h3F, then Empty=1.
- With queue full and FSM stalled in SEND, write 8'hAA -> Overflow=1, Level stays 16, 8'hAA never transmitted. ClrOvf pulse -> Overflow=0.
- Model holds TxDone high for 5 cycles -> exactly one frame per byte; next TxInit rises only after TxDone returns to 0.
- Assert Reset while TxInit=1 with Level=5 -> TxInit=0, Level=0, Empty=1 in the same cycle (async). No frame after release until a new write.
- With UART_TX_CRLF_EN, write 8'h48, 8'h0A -> frames 8'h48, 8'h0D, 8'h0A. Without the macro -> frames 8'h48, 8'h0A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: queue FSM state encodings, ASCII constants, baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    REL  = 2'd3
  } tx_state_e;

  localparam logic [7:0]  CR       = 8'h0D;
  localparam logic [7:0]  LF       = 8'h0A;

  // 50 MHz / 38400 baud, consumed by integrating tops that build the Uart itself
  localparam logic [15:0] BAUD_DIV = 16'd1302;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 synchronous FIFO storage with wrapping pointers and registered
// Full/Empty/Level flags; the head byte is presented combinationally.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [7:0]        wr_data_i,
  output logic [7:0]        head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  // Writes are gated by the registered Full, so a same-cycle pop never frees a slot
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer feeding the Uart over TxInit/TxData/TxDone.
// Define UART_TX_CRLF_EN to expand each LF into a CR,LF frame pair.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        WrData,
  input  logic              WrEn,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Level,
  output logic              Overflow,
  input  logic              ClrOvf,
  output logic              TxInit,
  output logic [7:0]        TxData,
  input  logic              TxDone,
  output logic              Busy
);

  tx_state_e   state_q;
  logic        tx_init_q;
  logic [7:0]  tx_data_q;
  logic        ovf_q;
  logic [7:0]  head;
  logic        fifo_full, fifo_empty;
  logic        pop_c, hold_lf_c;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .push_i    (WrEn),
    .pop_i     (pop_c),
    .wr_data_i (WrData),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (Level)
  );

`ifdef UART_TX_CRLF_EN
  logic cr_sent_q;

  // An LF at the head first launches a CR and stays queued for the following frame
  assign hold_lf_c = (head == LF) && !cr_sent_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                cr_sent_q <= 1'b0;
    else if (state_q == LOAD) cr_sent_q <= hold_lf_c;
  end
`else
  assign hold_lf_c = 1'b0;
`endif

  assign pop_c = (state_q == LOAD) && !hold_lf_c;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      tx_init_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) state_q <= LOAD;
        LOAD: begin
          tx_data_q <= hold_lf_c ? CR : head;
          tx_init_q <= 1'b1;
          state_q   <= SEND;
        end
        SEND: if (TxDone) begin
          tx_init_q <= 1'b0;
          state_q   <= REL;
        end
        // Level-style TxDone must fall before the next launch
        REL:  if (!TxDone) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                   ovf_q <= 1'b0;
    else if (WrEn && fifo_full)  ovf_q <= 1'b1;
    else if (ClrOvf)             ovf_q <= 1'b0;
  end

  assign Full     = fifo_full;
  assign Empty    = fifo_empty;
  assign Overflow = ovf_q;
  assign TxInit   = tx_init_q;
  assign TxData   = tx_data_q;
  assign Busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: Uart handshake model with a frame scoreboard, a
// per-cycle vector table for fill/overflow, and hand sequences for latency and reset.
module tb_uart_tx_queue;

  logic       Clock, Reset;
  logic [7:0] WrData;
  logic       WrEn, ClrOvf, TxDone;
  logic       Full, Empty, Overflow, TxInit, Busy;
  logic [4:0] Level;
  logic [7:0] TxData;

  uart_tx_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .WrData(WrData), .WrEn(WrEn),
    .Full(Full), .Empty(Empty), .Level(Level), .Overflow(Overflow),
    .ClrOvf(ClrOvf), .TxInit(TxInit), .TxData(TxData), .TxDone(TxDone),
    .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       model_en;
  int         done_delay, done_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] b);
`ifdef UART_TX_CRLF_EN
    if (b == 8'h0A) sb.push_back(8'h0D);
`endif
    sb.push_back(b);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_accept);
    WrEn = 1'b1;
    WrData = b;
    if (expect_accept) push_exp(b);
    tick();
    WrEn = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0 && Empty && !Busy && !TxDone) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_complete", 32'(ok), 32'd1);
  endtask

  // Uart model: picks up a frame when TxInit is high, raises TxDone after
  // done_delay cycles and holds it for done_hold cycles.
  bit         m_active;
  int         m_cnt, since_fall;
  logic [7:0] m_data;
  logic       prev_init;

  initial begin
    TxDone = 1'b0;
    m_active = 1'b0;
    m_cnt = 0;
    since_fall = 100;
    prev_init = 1'b0;
    m_data = 8'h00;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        TxDone = 1'b0;
        m_active = 1'b0;
        m_cnt = 0;
        since_fall = 100;
        prev_init = 1'b0;
      end else begin
        if (!TxDone && since_fall < 100) since_fall++;
        if (TxInit && !prev_init)
          chk("relaunch_gap_ge3", 32'(since_fall >= 3), 32'd1);
        if (!m_active && TxInit && model_en) begin
          m_active = 1'b1;
          m_cnt = 0;
          m_data = TxData;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got %0h expected none at %0t", TxData, $time);
          end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (TxData !== e) begin
              errors++;
              $display("FAIL frame_data: got %0h expected %0h at %0t", TxData, e, $time);
            end
          end
        end else if (m_active) begin
          if (TxInit) chk("txdata_stable", 32'(TxData), 32'(m_data));
          m_cnt++;
          if (m_cnt == done_delay) TxDone = 1'b1;
          if (m_cnt == done_delay + done_hold) begin
            TxDone = 1'b0;
            m_active = 1'b0;
            since_fall = 0;
          end
        end
        prev_init = TxInit;
      end
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic [4:0] level;
    logic       full, empty, ovf, txinit, busy;
    logic       push;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic wr, logic [7:0] d, logic clr, int lvl,
                              logic f, logic e, logic o, logic ti, logic psh);
    vec_t v;
    v.wr = wr; v.data = d; v.clr = clr; v.level = 5'(lvl);
    v.full = f; v.empty = e; v.ovf = o; v.txinit = ti; v.busy = 1'b1; v.push = psh;
    return v;
  endfunction

  initial begin
    // Fill/overflow table, applied one row per cycle with the Uart stalled
    vecs[0] = mk(1, 8'h5A, 0, 1, 0, 0, 0, 0, 1);
    vecs[1] = mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
    vecs[2] = mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++)
      vecs[3+i] = mk(1, 8'(8'h30 + i), 0, i + 1, (i == 15), 0, 0, 1, 1);
    vecs[19] = mk(1, 8'hAA, 0, 16, 1, 0, 1, 1, 0);
    vecs[20] = mk(0, 8'h00, 1, 16, 1, 0, 0, 1, 0);
    vecs[21] = mk(1, 8'hAA, 1, 16, 1, 0, 1, 1, 0);
    vecs[22] = mk(0, 8'h00, 1, 16, 1, 0, 0, 1, 0);

    Reset = 1'b1; WrEn = 1'b0; WrData = 8'h00; ClrOvf = 1'b0;
    model_en = 1'b1; done_delay = 20; done_hold = 1;
    #2;
    chk("rst_full",   32'(Full),     32'd0);
    chk("rst_empty",  32'(Empty),    32'd1);
    chk("rst_level",  32'(Level),    32'd0);
    chk("rst_ovf",    32'(Overflow), 32'd0);
    chk("rst_txinit", 32'(TxInit),   32'd0);
    chk("rst_txdata", 32'(TxData),   32'h00);
    chk("rst_busy",   32'(Busy),     32'd0);
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Single byte into an empty idle queue: TxInit on the 3rd edge
    WrEn = 1'b1; WrData = 8'h41; push_exp(8'h41);
    tick(); WrEn = 1'b0;
    chk("lat_e1_txinit", 32'(TxInit), 32'd0);
    tick();
    chk("lat_e2_txinit", 32'(TxInit), 32'd0);
    tick();
    chk("lat_e3_txinit", 32'(TxInit), 32'd1);
    chk("lat_e3_txdata", 32'(TxData), 32'h41);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (TxDone) begin seen = 1'b1; break; end
        tick();
      end
      chk("lat_txdone_seen", 32'(seen), 32'd1);
    end
    chk("lat_txinit_drop", 32'(TxInit), 32'd0);
    chk("lat_busy_rel",    32'(Busy),   32'd1);
    tick();
    chk("lat_busy_idle",   32'(Busy),   32'd0);
    chk("lat_empty_idle",  32'(Empty),  32'd1);

    // Fill with the FSM stalled in SEND, then overflow and clear
    model_en = 1'b0;
    for (int r = 0; r < 23; r++) begin
      WrEn = vecs[r].wr; WrData = vecs[r].data; ClrOvf = vecs[r].clr;
      if (vecs[r].wr && vecs[r].push) push_exp(vecs[r].data);
      tick();
      chk($sformatf("vec%0d_level", r),  32'(Level),    32'(vecs[r].level));
      chk($sformatf("vec%0d_full", r),   32'(Full),     32'(vecs[r].full));
      chk($sformatf("vec%0d_empty", r),  32'(Empty),    32'(vecs[r].empty));
      chk($sformatf("vec%0d_ovf", r),    32'(Overflow), 32'(vecs[r].ovf));
      chk($sformatf("vec%0d_txinit", r), 32'(TxInit),   32'(vecs[r].txinit));
      chk($sformatf("vec%0d_busy", r),   32'(Busy),     32'(vecs[r].busy));
    end
    WrEn = 1'b0; ClrOvf = 1'b0;
    model_en = 1'b1; done_delay = 6; done_hold = 1;
    wait_drain(2000);

    // Level-style TxDone held for 5 cycles
    done_delay = 4; done_hold = 5;
    write_byte(8'h61, 1'b1);
    write_byte(8'h62, 1'b1);
    write_byte(8'h63, 1'b1);
    wait_drain(500);

    // LF handling (expanded to CR,LF only when the option is built in)
    done_delay = 3; done_hold = 1;
    write_byte(8'h48, 1'b1);
    write_byte(8'h0A, 1'b1);
    wait_drain(500);

    // Reset in mid-frame with five bytes still queued
    model_en = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i), 1'b0);
    chk("prerst_txinit", 32'(TxInit), 32'd1);
    chk("prerst_level",  32'(Level),  32'd5);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_txinit", 32'(TxInit), 32'd0);
    chk("midrst_level",  32'(Level),  32'd0);
    chk("midrst_empty",  32'(Empty),  32'd1);
    chk("midrst_busy",   32'(Busy),   32'd0);
    tick();
    Reset = 1'b0;
    model_en = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("postrst_txinit", 32'(TxInit), 32'd0);
    chk("postrst_empty",  32'(Empty),  32'd1);
    write_byte(8'h77, 1'b1);
    wait_drain(500);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
